// File: rtl/frame_config_writer.sv
// Fabric configuration port writer: turns a 32-bit word stream into FrameData rows
// and a single one-hot FrameStrobe pulse per frame in the addressed column.
module frame_config_writer #(
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned NumRows         = 16,
  parameter int unsigned NumColumns      = 10,
  parameter int unsigned StrobeCycles    = 2,
  parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
  input  logic                                    CLK,
  input  logic                                    RST,
  input  logic [31:0]                             s_data,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  output logic [FrameBitsPerRow*NumRows-1:0]      FrameData,
  output logic [MaxFramesPerCol*NumColumns-1:0]   FrameStrobe,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    err
);

  localparam int unsigned RowW     = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int unsigned ColW     = (NumColumns > 1) ? $clog2(NumColumns) : 1;
  localparam int unsigned FrmW     = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
  localparam int unsigned StbW     = $clog2(StrobeCycles + 1);
  localparam int unsigned StrbBits = MaxFramesPerCol * NumColumns;
  localparam int unsigned IdxW     = (StrbBits > 1) ? $clog2(StrbBits) : 1;
  localparam logic [31:0] EndWord  = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_DISCARD,
    S_STROBE
  } state_e;

  state_e                             state_q;
  logic [RowW-1:0]                    row_q;
  logic [StbW-1:0]                    strb_cnt_q;
  logic [ColW-1:0]                    col_q;
  logic [FrmW-1:0]                    frame_q;
  logic [FrameBitsPerRow*NumRows-1:0] frame_data_q;
  logic [StrbBits-1:0]                frame_strobe_q;
  logic                               done_q;
  logic                               err_q;

  logic            xfer_c;
  logic [7:0]      cmd_col_c;
  logic [7:0]      cmd_frame_c;
  logic            cmd_ok_c;
  logic [IdxW-1:0] strobe_idx_c;

  // Handshake and command decode
  assign s_ready      = (state_q != S_STROBE);
  assign xfer_c       = s_valid && s_ready;
  assign cmd_col_c    = s_data[31:24];
  assign cmd_frame_c  = s_data[23:16];
  assign cmd_ok_c     = (32'(cmd_col_c) < NumColumns) && (32'(cmd_frame_c) < MaxFramesPerCol);
  assign strobe_idx_c = IdxW'(32'(col_q) * MaxFramesPerCol + 32'(frame_q));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= S_IDLE;
      row_q          <= '0;
      strb_cnt_q     <= '0;
      col_q          <= '0;
      frame_q        <= '0;
      frame_data_q   <= '0;
      frame_strobe_q <= '0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (xfer_c && (s_data == SyncWord)) begin
            state_q <= S_CMD;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        S_CMD: begin
          if (xfer_c) begin
            row_q <= '0;
            if (s_data == EndWord) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else if (cmd_ok_c) begin
              col_q   <= ColW'(cmd_col_c);
              frame_q <= FrmW'(cmd_frame_c);
              state_q <= S_DATA;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_DISCARD;
            end
          end
        end
        S_DATA: begin
          if (xfer_c) begin
            frame_data_q[32'(row_q)*FrameBitsPerRow +: FrameBitsPerRow] <= FrameBitsPerRow'(s_data);
            if (row_q == RowW'(NumRows - 1)) begin
              // Strobe rises together with the last row write
              state_q                      <= S_STROBE;
              strb_cnt_q                   <= '0;
              frame_strobe_q               <= '0;
              frame_strobe_q[strobe_idx_c] <= 1'b1;
            end else begin
              row_q <= row_q + RowW'(1);
            end
          end
        end
        S_DISCARD: begin
          if (xfer_c) begin
            if (row_q == RowW'(NumRows - 1)) begin
              state_q <= S_CMD;
            end else begin
              row_q <= row_q + RowW'(1);
            end
          end
        end
        S_STROBE: begin
          if (strb_cnt_q == StbW'(StrobeCycles - 1)) begin
            frame_strobe_q <= '0;
            state_q        <= S_CMD;
          end else begin
            strb_cnt_q <= strb_cnt_q + StbW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign FrameData   = frame_data_q;
  assign FrameStrobe = frame_strobe_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_frame_config_writer.sv
// Self-checking bench for frame_config_writer: directed scenarios with random row data,
// compared against a frame-level reference model and a strobe event monitor.
module tb_frame_config_writer;

  localparam int unsigned NR = 16;
  localparam int unsigned NC = 10;
  localparam int unsigned MF = 20;
  localparam int unsigned SB = MF * NC;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
  localparam logic [31:0] ENDW = 32'hFFFF_FFFF;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [31:0]     s_data = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [NR*32-1:0] FrameData;
  logic [SB-1:0]   FrameStrobe;
  logic            busy;
  logic            done;
  logic            err;

  frame_config_writer dut (
    .CLK         (CLK),
    .RST         (RST),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Strobe monitor: logs every high strobe bit per cycle and tracks invariants
  typedef struct {
    int c;
    int idx;
  } ev_t;
  ev_t ev_q[$];
  int  onehot_bad = 0;
  int  fd_change_bad = 0;
  logic [SB-1:0]    prev_strb = '0;
  logic [NR*32-1:0] prev_fd = '0;

  always @(negedge CLK) begin
    ev_t e;
    if ($countones(FrameStrobe) > 1) onehot_bad <= onehot_bad + 1;
    if ((prev_strb != '0) && (FrameData != prev_fd)) fd_change_bad <= fd_change_bad + 1;
    for (int i = 0; i < int'(SB); i++) begin
      if (FrameStrobe[i]) begin
        e.c = cyc;
        e.idx = i;
        ev_q.push_back(e);
      end
    end
    prev_strb <= FrameStrobe;
    prev_fd   <= FrameData;
  end

  // Reference model: expected row contents of the fabric configuration port
  logic [31:0] exp_rows [NR];

  function automatic logic [NR*32-1:0] exp_fd();
    logic [NR*32-1:0] v;
    for (int r = 0; r < int'(NR); r++) v[r*32 +: 32] = exp_rows[r];
    return v;
  endfunction

  function automatic bit cmd_ok(input int col, input int frame);
    return (col < int'(NC)) && (frame < int'(MF));
  endfunction

  function automatic int strobe_pos(input int col, input int frame);
    return col * int'(MF) + frame;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < int'(NR); r++) exp_rows[r] = '0;
  endtask

  task automatic push(input logic [31:0] w);
    bit took;
    int n;
    took = 0;
    n = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!took && n < 20) begin
      took = s_ready;
      @(posedge CLK);
      #1;
      n++;
    end
    if (!took) begin
      checks++;
      errors++;
      $display("FAIL push_timeout word %08h not accepted within 20 cycles", w);
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) begin
      s_data = $urandom;
      @(posedge CLK);
      #1;
    end
  endtask

  // Sends a command plus NR rows (base+r or random), updating the model
  task automatic send_frame(input int col, input int frame, input bit rnd, input logic [31:0] base);
    logic [31:0] d;
    push({8'(col), 8'(frame), 16'h0000});
    for (int r = 0; r < int'(NR); r++) begin
      d = rnd ? 32'($urandom) : base + 32'(r);
      if (cmd_ok(col, frame)) exp_rows[r] = d;
      push(d);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    s_valid = 1'b0;
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    model_reset();
    checks++; if (FrameData !== exp_fd()) begin errors++; $display("FAIL reset_fd got %0h exp 0", FrameData); end
    checks++; if (FrameStrobe !== '0) begin errors++; $display("FAIL reset_strobe got %0h exp 0", FrameStrobe); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, done, err}); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", s_ready); end
    RST = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [SB-1:0] es;
    int c0;
    es = '0;
    es[strobe_pos(3, 5)] = 1'b1;
    push(SYNC);
    push(32'h0305_0000);
    c0 = cyc;
    for (int r = 0; r < int'(NR); r++) begin
      exp_rows[r] = 32'hA000_0000 + 32'(r);
      push(32'hA000_0000 + 32'(r));
    end
    s_valid = 1'b0;
    checks++; if (cyc !== c0 + 16) begin errors++; $display("FAIL t1_no_stall got %0d exp %0d", cyc - c0, 16); end
    for (int k = 0; k < 2; k++) begin
      checks++; if (FrameStrobe !== es) begin errors++; $display("FAIL t1_strobe_hi%0d got %0h exp %0h", k, FrameStrobe, es); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL t1_ready_lo%0d got %b exp 0", k, s_ready); end
      @(posedge CLK);
      #1;
    end
    checks++; if (FrameStrobe !== '0) begin errors++; $display("FAIL t1_strobe_off got %0h exp 0", FrameStrobe); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL t1_ready_back got %b exp 1", s_ready); end
    checks++; if (FrameData !== exp_fd()) begin errors++; $display("FAIL t1_rows got %0h exp %0h", FrameData, exp_fd()); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    ev_q.delete();
    push(32'h0000_0000);
    for (int r = 0; r < int'(NR); r++) begin
      d = $urandom;
      exp_rows[r] = d;
      push(d);
    end
    push(32'h0913_0000);
    for (int r = 0; r < int'(NR); r++) begin
      d = $urandom;
      exp_rows[r] = d;
      push(d);
    end
    s_valid = 1'b0;
    idle(4);
    checks++;
    if (ev_q.size() !== 4) begin
      errors++; $display("FAIL t2_events got %0d exp 4", ev_q.size());
    end else begin
      checks++; if ({ev_q[0].idx, ev_q[1].idx} !== {strobe_pos(0, 0), strobe_pos(0, 0)})
        begin errors++; $display("FAIL t2_idx_a got %0d,%0d exp 0,0", ev_q[0].idx, ev_q[1].idx); end
      checks++; if ({ev_q[2].idx, ev_q[3].idx} !== {strobe_pos(9, 19), strobe_pos(9, 19)})
        begin errors++; $display("FAIL t2_idx_b got %0d,%0d exp 199,199", ev_q[2].idx, ev_q[3].idx); end
      checks++; if (ev_q[2].c - ev_q[1].c - 1 !== 17)
        begin errors++; $display("FAIL t2_gap got %0d exp 17", ev_q[2].c - ev_q[1].c - 1); end
      checks++; if ((ev_q[1].c - ev_q[0].c !== 1) || (ev_q[3].c - ev_q[2].c !== 1))
        begin errors++; $display("FAIL t2_width got %0d,%0d exp 1,1", ev_q[1].c - ev_q[0].c, ev_q[3].c - ev_q[2].c); end
    end
    checks++; if (fd_change_bad !== 0) begin errors++; $display("FAIL t2_fd_stable got %0d exp 0", fd_change_bad); end
    checks++; if (FrameData !== exp_fd()) begin errors++; $display("FAIL t2_rows got %0h exp %0h", FrameData, exp_fd()); end
  endtask

  task automatic test_bad_address();
    ev_q.delete();
    push(32'h0A00_0000);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL t3_err_set got %b exp 1", err); end
    for (int r = 0; r < int'(NR); r++) push($urandom);
    s_valid = 1'b0;
    idle(3);
    checks++; if (FrameData !== exp_fd()) begin errors++; $display("FAIL t3_rows_kept got %0h exp %0h", FrameData, exp_fd()); end
    checks++; if (ev_q.size() !== 0) begin errors++; $display("FAIL t3_no_strobe got %0d exp 0", ev_q.size()); end
    send_frame(2, 7, 1'b1, 32'h0);
    idle(3);
    checks++;
    if (ev_q.size() !== 2) begin
      errors++; $display("FAIL t3_next_events got %0d exp 2", ev_q.size());
    end else begin
      checks++; if (ev_q[0].idx !== strobe_pos(2, 7)) begin errors++; $display("FAIL t3_next_idx got %0d exp %0d", ev_q[0].idx, strobe_pos(2, 7)); end
    end
    checks++; if (FrameData !== exp_fd()) begin errors++; $display("FAIL t3_next_rows got %0h exp %0h", FrameData, exp_fd()); end
    ev_q.delete();
    send_frame(1, 20, 1'b1, 32'h0);
    idle(3);
    checks++; if (ev_q.size() !== 0) begin errors++; $display("FAIL t3_frame_oor got %0d exp 0", ev_q.size()); end
    checks++; if ({err, FrameData} !== {1'b1, exp_fd()}) begin errors++; $display("FAIL t3_frame_oor_state err %b", err); end
  endtask

  task automatic test_sync_end();
    push(ENDW);
    s_valid = 1'b0;
    checks++; if ({done, busy, err} !== 3'b101) begin errors++; $display("FAIL t4_end_cmd got %b exp 101", {done, busy, err}); end
    push(32'h1234_5678);
    push(32'h0000_0000);
    s_valid = 1'b0;
    checks++; if ({busy, done} !== 2'b01) begin errors++; $display("FAIL t4_junk got %b exp 01", {busy, done}); end
    push(SYNC);
    s_valid = 1'b0;
    checks++; if ({busy, done, err} !== 3'b100) begin errors++; $display("FAIL t4_sync got %b exp 100", {busy, done, err}); end
    push(ENDW);
    s_valid = 1'b0;
    checks++; if ({busy, done} !== 2'b01) begin errors++; $display("FAIL t4_end got %b exp 01", {busy, done}); end
  endtask

  task automatic test_valid_gaps();
    int c0;
    ev_q.delete();
    push(SYNC);
    push(32'h0305_0000);
    c0 = cyc;
    for (int r = 0; r < 8; r++) begin
      exp_rows[r] = 32'hA000_0000 + 32'(r);
      push(32'hA000_0000 + 32'(r));
    end
    idle(5);
    for (int r = 8; r < int'(NR); r++) begin
      exp_rows[r] = 32'hA000_0000 + 32'(r);
      push(32'hA000_0000 + 32'(r));
    end
    s_valid = 1'b0;
    idle(4);
    checks++;
    if (ev_q.size() !== 2) begin
      errors++; $display("FAIL t5_events got %0d exp 2", ev_q.size());
    end else begin
      checks++; if (ev_q[0].c - c0 !== 21) begin errors++; $display("FAIL t5_delay got %0d exp 21", ev_q[0].c - c0); end
      checks++; if (ev_q[1].idx !== strobe_pos(3, 5)) begin errors++; $display("FAIL t5_idx got %0d exp 65", ev_q[1].idx); end
    end
    checks++; if (FrameData !== exp_fd()) begin errors++; $display("FAIL t5_rows got %0h exp %0h", FrameData, exp_fd()); end
  endtask

  task automatic test_mid_frame_reset();
    ev_q.delete();
    push(SYNC);
    push(32'h0102_0000);
    for (int r = 0; r < 7; r++) push(32'hB000_0000 + 32'(r));
    s_valid = 1'b0;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
    checks++; if (FrameData !== exp_fd()) begin errors++; $display("FAIL t6_fd got %0h exp 0", FrameData); end
    checks++; if ({FrameStrobe != '0, busy, done, err} !== 4'b0000) begin errors++; $display("FAIL t6_outs got %b exp 0000", {FrameStrobe != '0, busy, done, err}); end
    for (int r = 7; r < int'(NR); r++) push(32'hB000_0000 + 32'(r));
    s_valid = 1'b0;
    idle(4);
    checks++; if (ev_q.size() !== 0) begin errors++; $display("FAIL t6_no_strobe got %0d exp 0", ev_q.size()); end
    checks++; if ({busy, FrameData} !== {1'b0, exp_fd()}) begin errors++; $display("FAIL t6_ignored busy %b", busy); end
    push(SYNC);
    send_frame(1, 2, 1'b1, 32'h0);
    idle(3);
    checks++;
    if (ev_q.size() !== 2) begin
      errors++; $display("FAIL t6_restart_events got %0d exp 2", ev_q.size());
    end else begin
      checks++; if (ev_q[0].idx !== strobe_pos(1, 2)) begin errors++; $display("FAIL t6_restart_idx got %0d exp 22", ev_q[0].idx); end
    end
    checks++; if (FrameData !== exp_fd()) begin errors++; $display("FAIL t6_restart_rows got %0h exp %0h", FrameData, exp_fd()); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_bad_address();
    test_sync_end();
    test_valid_gaps();
    test_mid_frame_reset();
    checks++; if (onehot_bad !== 0) begin errors++; $display("FAIL onehot got %0d exp 0", onehot_bad); end
    checks++; if (fd_change_bad !== 0) begin errors++; $display("FAIL fd_stable got %0d exp 0", fd_change_bad); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
